// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the UART boot loader.
// Optional checksum support is enabled by defining UART_BOOT_CHECKSUM_EN.
package boot_pkg;

  typedef enum logic [2:0] {
    LEN_LO = 3'd0,
    LEN_HI = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    RUN    = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam int WORD_BYTES    = 4;
  localparam int MAX_WORDS_DEF = 2048;

endpackage

// File: rtl/uart_boot_loader_if.sv
// UART read side and RAM write port of the boot loader, bundled.
// master = loader, slave = surrounding system (UART FIFO, RAM, CPU reset).
interface uart_boot_loader_if #(
  parameter int ADDR_W = 11
);
  logic              rx_empty;
  logic [7:0]        rx_data;
  logic              rd_uart;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_we;
  logic              cpu_hold;
  logic              done;
  logic              error;

  modport master (
    input  rx_empty, rx_data,
    output rd_uart, ram_addr, ram_wdata, ram_we, cpu_hold, done, error
  );

  modport slave (
    output rx_empty, rx_data,
    input  rd_uart, ram_addr, ram_wdata, ram_we, cpu_hold, done, error
  );
endinterface

// File: rtl/uart_boot_loader_byte_packer.sv
// Packs a byte stream into little-endian 32-bit words; word_valid pulses
// for one cycle after the fourth byte of a word is accepted.
module byte_packer
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_vld,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane;
  logic [23:0] lanes;

  // lane counter, lower-lane shift register and the completed-word register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane       <= '0;
      lanes      <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (byte_vld) begin
        lane <= lane + 2'd1;
        if (lane == 2'(WORD_BYTES - 1)) begin
          word       <= {byte_in, lanes};
          word_valid <= 1'b1;
        end else begin
          case (lane)
            2'd0:    lanes[7:0]   <= byte_in;
            2'd1:    lanes[15:8]  <= byte_in;
            default: lanes[23:16] <= byte_in;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Boot loader: holds the CPU in reset, pulls a length-prefixed image from
// the UART FIFO, writes it to RAM as little-endian words, then releases the CPU.
// Define UART_BOOT_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input logic               clk,
  input logic               reset,
  uart_boot_loader_if.master bus
);

  state_t          state, state_nx;
  logic [15:0]     len;
  logic [15:0]     len_full;
  logic [ADDR_W:0] word_cnt;
  logic            pop;
  logic            last;
  logic            pk_vld;
  logic            word_valid;
  logic [31:0]     word;
  logic            cpu_hold_q, done_q, error_q;
`ifdef UART_BOOT_CHECKSUM_EN
  logic [7:0]      csum;
`endif

  // length as it will be once the current LEN_HI byte is captured
  assign len_full = {bus.rx_data, len[7:0]};
  // the final word of the image is in its write cycle
  assign last = word_valid && ((17'(word_cnt) + 17'd1) == {1'b0, len});

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .byte_vld   (pk_vld),
    .byte_in    (bus.rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LEN_LO;
    else        state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      LEN_LO: if (pop) state_nx = LEN_HI;
      LEN_HI: if (pop) begin
        if (len_full == 16'd0)
`ifdef UART_BOOT_CHECKSUM_EN
          state_nx = CSUM;
`else
          state_nx = RUN;
`endif
        else if ({1'b0, len_full} > 17'(MAX_WORDS))
          state_nx = ERR;
        else
          state_nx = DATA;
      end
      DATA: if (last)
`ifdef UART_BOOT_CHECKSUM_EN
        state_nx = CSUM;
`else
        state_nx = RUN;
`endif
`ifdef UART_BOOT_CHECKSUM_EN
      CSUM: if (pop) state_nx = (bus.rx_data == csum) ? RUN : ERR;
`endif
      default: state_nx = state;
    endcase
  end

  // output logic: pop strobe (no pop while the last word is being written)
  always_comb begin
    pop    = 1'b0;
    pk_vld = 1'b0;
    case (state)
      LEN_LO, LEN_HI: pop = !bus.rx_empty;
      DATA: begin
        pop    = !bus.rx_empty && !last;
        pk_vld = pop;
      end
`ifdef UART_BOOT_CHECKSUM_EN
      CSUM: pop = !bus.rx_empty;
`endif
      default: pop = 1'b0;
    endcase
    // never pop the FIFO while held in reset
    pop    = pop && reset;
    pk_vld = pk_vld && reset;
  end

  // header capture, word counter and optional running XOR
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len      <= '0;
      word_cnt <= '0;
`ifdef UART_BOOT_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      if (pop && state == LEN_LO) len[7:0]  <= bus.rx_data;
      if (pop && state == LEN_HI) len[15:8] <= bus.rx_data;
      if (word_valid)             word_cnt  <= word_cnt + 1'b1;
`ifdef UART_BOOT_CHECKSUM_EN
      if (pop)                    csum      <= csum ^ bus.rx_data;
`endif
    end
  end

  // registered status flags follow the terminal states
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      cpu_hold_q <= (state != RUN);
      done_q     <= (state == RUN);
      error_q    <= (state == ERR);
    end
  end

  assign bus.rd_uart   = pop;
  assign bus.ram_we    = word_valid ? 4'hF : 4'h0;
  assign bus.ram_wdata = word;
  assign bus.ram_addr  = word_cnt[ADDR_W-1:0];
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Randomized bench for uart_boot_loader with a byte-stream reference model.
module tb_uart_boot_loader;

  localparam int ADDR_W = 11;
  localparam int MAXW   = 2048;
`ifdef UART_BOOT_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();
  uart_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAXW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, done_cyc = -1, stall_pct = 0;
  logic [7:0]        q[$];
  int                pop_cyc[$];
  logic [ADDR_W-1:0] w_addr[$];
  logic [31:0]       w_data[$];
  int                w_cyc[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_in();
    bus.rx_empty = (q.size() == 0) || ($urandom_range(99) < stall_pct);
    bus.rx_data  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  // one clock: sample at negedge, FIFO pops on posedge, new inputs #1 later
  task automatic step();
    logic pend;
    @(negedge clk);
    if (bus.rd_uart) pop_cyc.push_back(cyc);
    if (bus.ram_we != 4'h0) begin
      chk("we_full", 64'(bus.ram_we), 64'hF);
      w_addr.push_back(bus.ram_addr);
      w_data.push_back(bus.ram_wdata);
      w_cyc.push_back(cyc);
    end
    if (bus.done && done_cyc < 0) done_cyc = cyc;
    pend = bus.rd_uart;
    @(posedge clk);
    cyc++;
    if (pend) begin
      if (q.size() == 0) chk("pop_when_empty", 64'd1, 64'd0);
      else void'(q.pop_front());
    end
    #1 drive_in();
  endtask

  // one-cycle reset with a byte waiting, checking the reset values
  task automatic do_reset();
    reset = 1'b0;
    q.delete();
    q.push_back(8'h5A);
    stall_pct = 0;
    drive_in();
    @(negedge clk);
    chk("rst_cpu_hold", 64'(bus.cpu_hold), 64'd1);
    chk("rst_done",     64'(bus.done),     64'd0);
    chk("rst_error",    64'(bus.error),    64'd0);
    chk("rst_rd_uart",  64'(bus.rd_uart),  64'd0);
    chk("rst_ram_we",   64'(bus.ram_we),   64'd0);
    chk("rst_ram_addr", 64'(bus.ram_addr), 64'd0);
    chk("rst_wdata",    64'(bus.ram_wdata), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    q.delete();
    drive_in();
    pop_cyc.delete(); w_addr.delete(); w_data.delete(); w_cyc.delete();
    cyc = 0;
    done_cyc = -1;
  endtask

  // header + payload (+ checksum when enabled; bad_cs flips it)
  task automatic mk_image(input int len, input bq_t payload, input bit bad_cs, output bq_t img);
    logic [7:0] x;
    img = {};
    img.push_back(8'(len));
    img.push_back(8'(len >> 8));
    foreach (payload[i]) img.push_back(payload[i]);
    if (CS) begin
      x = 8'h00;
      foreach (img[i]) x ^= img[i];
      img.push_back(bad_cs ? ~x : x);
    end
  endtask

  task automatic rand_payload(input int nwords, output bq_t p);
    p = {};
    for (int i = 0; i < 4 * nwords; i++) p.push_back(8'($urandom));
  endtask

  // reference model from the image rules, then run and compare
  task automatic run_image(input string nm, input bq_t img, input int stall);
    int len, exp_pops, nw, budget;
    bit exp_err;
    logic [7:0]  x;
    logic [31:0] exp_w[$];
    len = int'(img[0]) | (int'(img[1]) << 8);
    exp_w = {};
    if (len > MAXW) begin
      exp_err = 1'b1;
      exp_pops = 2;
    end else begin
      for (int i = 0; i < len; i++)
        exp_w.push_back({img[2+4*i+3], img[2+4*i+2], img[2+4*i+1], img[2+4*i]});
      exp_pops = 2 + 4 * len + (CS ? 1 : 0);
      exp_err = 1'b0;
      if (CS) begin
        x = 8'h00;
        for (int i = 0; i < 2 + 4 * len; i++) x ^= img[i];
        exp_err = (img[2 + 4 * len] != x);
      end
    end
    q = img;
    for (int i = 0; i < 3; i++) q.push_back(8'hC0 + 8'(i));
    stall_pct = stall;
    drive_in();
    budget = 20 * img.size() + 200;
    for (int k = 0; k < budget; k++) begin
      step();
      if (bus.done || bus.error) break;
    end
    if (!(bus.done || bus.error)) chk({nm, "_timeout"}, 64'd0, 64'd1);
    repeat (8) step();
    chk({nm, "_done"},     64'(bus.done),     64'(!exp_err));
    chk({nm, "_error"},    64'(bus.error),    64'(exp_err));
    chk({nm, "_cpu_hold"}, 64'(bus.cpu_hold), 64'(exp_err));
    chk({nm, "_pops"},     64'(pop_cyc.size()), 64'(exp_pops));
    chk({nm, "_nwrites"},  64'(w_data.size()),  64'(exp_w.size()));
    nw = (w_data.size() < exp_w.size()) ? w_data.size() : exp_w.size();
    for (int i = 0; i < nw; i++) begin
      chk({nm, "_addr"}, 64'(w_addr[i]), 64'(i));
      chk({nm, "_data"}, 64'(w_data[i]), 64'(exp_w[i]));
      if (2 + 4 * i + 3 < pop_cyc.size())
        chk({nm, "_wr_lat"}, 64'(w_cyc[i]), 64'(pop_cyc[2 + 4 * i + 3] + 1));
    end
    if (len == 0 && pop_cyc.size() > 0)
      chk({nm, "_run_lat"}, 64'(done_cyc), 64'(pop_cyc[pop_cyc.size() - 1] + 2));
  endtask

  initial begin
    bq_t p, img;
    bus.rx_empty = 1'b1;
    bus.rx_data  = 8'h00;
    repeat (2) @(posedge clk);

    // two-word directed image
    do_reset();
    p = {8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    mk_image(2, p, 1'b0, img);
    run_image("two_words", img, 0);

    // zero-length image
    do_reset();
    p = {};
    mk_image(0, p, 1'b0, img);
    run_image("len_zero", img, 0);

    // oversize length 0x0801
    do_reset();
    img = {8'h01, 8'h08, 8'h11, 8'h22, 8'h33, 8'h44};
    run_image("oversize", img, 0);

    // three words with random FIFO stalls
    do_reset();
    rand_payload(3, p);
    mk_image(3, p, 1'b0, img);
    run_image("stall3", img, 45);

    // reset part-way through a load, then a fresh one-word image
    do_reset();
    q = {8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    drive_in();
    for (int k = 0; k < 200 && pop_cyc.size() < 7; k++) step();
    chk("midload_pops", 64'(pop_cyc.size()), 64'd7);
    do_reset();
    p = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
    mk_image(1, p, 1'b0, img);
    run_image("after_abort", img, 20);

    // random images
    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(8, 1);
      do_reset();
      rand_payload(n, p);
      mk_image(n, p, 1'b0, img);
      run_image("random", img, $urandom_range(50, 0));
    end

    // largest accepted image
    do_reset();
    rand_payload(MAXW, p);
    mk_image(MAXW, p, 1'b0, img);
    run_image("max_len", img, 0);

`ifdef UART_BOOT_CHECKSUM_EN
    do_reset();
    img = {8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    run_image("csum_good", img, 0);
    do_reset();
    img = {8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h46};
    run_image("csum_bad", img, 0);
    do_reset();
    rand_payload(4, p);
    mk_image(4, p, 1'b1, img);
    run_image("csum_rand_bad", img, 30);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
